// File: rtl/parallel_addsub_4bit.sv
// parallel_addsub_4bit
// Registered 4-bit adder/subtractor built from a ripple chain of four
// full-adder stages. sign=0 adds (a + b), sign=1 subtracts (a - b) by
// inverting b and injecting sign as the stage-0 carry. Every stage carry
// is registered on c_out so downstream logic can read carry/borrow.
// Optional feature macro: PARALLEL_ADDSUB_OVF_EN adds the registered
// signed-overflow output ovf (co[3] ^ co[2]).

module parallel_addsub_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sign,
    output logic [3:0] s,
    output logic [3:0] c_out
`ifdef PARALLEL_ADDSUB_OVF_EN
    ,
    output logic       ovf
`endif
);

    logic [3:0] w_bx;
    logic [3:0] w_cin;
    logic [3:0] w_sum;
    logic [3:0] w_co;

    logic [3:0] r_s;
    logic [3:0] r_c_out;

    // Ripple chain: condition b per bit, then four full-adder stages
    always_comb begin
        w_bx  = b ^ {4{sign}};
        w_cin = 4'b0000;
        w_sum = 4'b0000;
        w_co  = 4'b0000;
        w_cin[0] = sign;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                w_cin[i] = w_co[i-1];
            end
            w_sum[i] = a[i] ^ w_bx[i] ^ w_cin[i];
            w_co[i]  = (a[i] & w_bx[i]) | (a[i] & w_cin[i]) | (w_bx[i] & w_cin[i]);
        end
    end

    // Result and carry registers; synchronous reset clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= 4'b0000;
            r_c_out <= 4'b0000;
        end else begin
            r_s     <= w_sum;
            r_c_out <= w_co;
        end
    end

    assign s     = r_s;
    assign c_out = r_c_out;

`ifdef PARALLEL_ADDSUB_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the sign stage differs from carry out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_co[3] ^ w_co[2];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_parallel_addsub_4bit.sv
// Testbench for parallel_addsub_4bit: directed steps, exhaustive
// back-to-back sweep and randomized traffic against an arithmetic model.
// Build with PARALLEL_ADDSUB_OVF_EN defined to also check ovf.

module tb_parallel_addsub_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       sign;
    logic [3:0] s;
    logic [3:0] c_out;
    logic       ovf_obs;

    int checks;
    int errors;

    parallel_addsub_4bit dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sign  (sign),
        .s     (s),
        .c_out (c_out)
`ifdef PARALLEL_ADDSUB_OVF_EN
        ,
        .ovf   (ovf_obs)
`endif
    );

`ifndef PARALLEL_ADDSUB_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, carries, sum} from plain integer arithmetic
    function automatic logic [8:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic msub);
        int         bx;
        int         tot;
        int         m;
        int         sa;
        int         sb;
        int         r;
        logic [3:0] c;
        logic [3:0] sum;
        logic       ov;
        bx = int'(msub ? ~mb : mb);
        for (int i = 0; i < 4; i++) begin
            m    = (1 << (i + 1)) - 1;
            tot  = (int'(ma) & m) + (bx & m) + int'(msub);
            c[i] = ((tot >> (i + 1)) & 1) != 0;
        end
        tot = int'(ma) + bx + int'(msub);
        sum = tot[3:0];
        sa  = (ma >= 4'd8) ? int'(ma) - 16 : int'(ma);
        sb  = (mb >= 4'd8) ? int'(mb) - 16 : int'(mb);
        r   = msub ? sa - sb : sa + sb;
        ov  = (r > 7) || (r < -8);
        return {ov, c, sum};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        checks++;
        assert (s === exp[3:0]) else begin
            errors++;
            $error("FAIL %s s observed=%b expected=%b", tag, s, exp[3:0]);
        end
        checks++;
        assert (c_out === exp[7:4]) else begin
            errors++;
            $error("FAIL %s c_out observed=%b expected=%b", tag, c_out, exp[7:4]);
        end
`ifdef PARALLEL_ADDSUB_OVF_EN
        checks++;
        assert (ovf_obs === exp[8]) else begin
            errors++;
            $error("FAIL %s ovf observed=%b expected=%b", tag, ovf_obs, exp[8]);
        end
`endif
    endtask

    // Drive one vector, let one edge pass, compare against the model
    task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic tsub, input logic trst);
        rst  = trst;
        a    = ta;
        b    = tb_v;
        sign = tsub;
        @(negedge clk);
        if (trst) check(tag, 9'd0);
        else      check(tag, model(ta, tb_v, tsub));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        a    = 4'hA;
        b    = 4'h5;
        sign = 1'b1;

        // Reset for two edges with arbitrary inputs
        @(negedge clk);
        @(negedge clk);
        check("reset", 9'd0);

        // Directed test-plan vectors with literal expectations
        step("sub_0_2", 4'b0000, 4'b0010, 1'b1, 1'b0);
        check("sub_0_2_lit", {1'b0, 4'b0001, 4'b1110});
        step("add_5_3", 4'b0101, 4'b0011, 1'b0, 1'b0);
        check("add_5_3_lit", {1'b1, 4'b0111, 4'b1000});
        step("sub_8_6", 4'b1000, 4'b0110, 1'b1, 1'b0);
        check("sub_8_6_lit", {1'b1, 4'b1001, 4'b0010});
        step("add_9_8", 4'b1001, 4'b1000, 1'b0, 1'b0);
        check("add_9_8_lit", {1'b1, 4'b1000, 4'b0001});
        step("midstream_rst", 4'b0111, 4'b0111, 1'b0, 1'b1);
        step("after_rst", 4'b0011, 4'b0100, 1'b0, 1'b0);
        check("after_rst_lit", {1'b0, 4'b0000, 4'b0111});

        // Sign change alone alters the next result
        step("sign_flip_add", 4'b0110, 4'b0110, 1'b0, 1'b0);
        step("sign_flip_sub", 4'b0110, 4'b0110, 1'b1, 1'b0);
        check("sign_flip_sub_lit", {1'b0, 4'b1111, 4'b0000});

        // Exhaustive sweep, a new vector every cycle
        for (int n = 0; n < 512; n++) begin
            step("exhaustive", n[3:0], n[7:4], n[8], 1'b0);
        end

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 300; n++) begin
            step("random", 4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
